// File: rtl/display_scan_7seg.sv
// Four-digit multiplexed 7-segment scanner.
// Double-buffered digits, swapped into the active set at the end of each sweep.
module display_scan_7seg #(
  parameter int DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligado,
  input  logic [15:0] digitos,
  input  logic [3:0]  pontos,
  input  logic        carregar,
  output logic [1:0]  contador,
  output logic [6:0]  segmentos,
  output logic        ponto,
  output logic        fim_varredura
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [15:0]   shadow_dig;
  logic [3:0]    shadow_pt;
  logic [15:0]   active_dig;
  logic [3:0]    active_pt;
  logic [3:0]    nib;
  logic          pt_sel;
  logic [6:0]    seg_dec;

  assign tick          = ligado && (div_cnt == LAST);
  assign fim_varredura = tick && (contador == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt    <= '0;
      contador   <= '0;
      shadow_dig <= '0;
      shadow_pt  <= '0;
      active_dig <= '0;
      active_pt  <= '0;
    end else begin
      if (carregar) begin
        shadow_dig <= digitos;
        shadow_pt  <= pontos;
      end
      // active takes the pre-edge shadow, so a same-cycle load waits a sweep
      if (fim_varredura) begin
        active_dig <= shadow_dig;
        active_pt  <= shadow_pt;
      end
      if (!ligado) begin
        div_cnt  <= '0;
        contador <= '0;
      end else if (tick) begin
        div_cnt  <= '0;
        contador <= contador + 2'd1;
      end else begin
        div_cnt  <= div_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    nib    = active_dig[3:0];
    pt_sel = active_pt[0];
    unique case (contador)
      2'd0: begin nib = active_dig[3:0];   pt_sel = active_pt[0]; end
      2'd1: begin nib = active_dig[7:4];   pt_sel = active_pt[1]; end
      2'd2: begin nib = active_dig[11:8];  pt_sel = active_pt[2]; end
      2'd3: begin nib = active_dig[15:12]; pt_sel = active_pt[3]; end
    endcase
  end

  always_comb begin
    seg_dec = 7'b1111111;
    unique case (nib)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
    endcase
  end

  assign segmentos = ligado ? seg_dec : 7'b1111111;
  assign ponto     = ligado ? ~pt_sel : 1'b1;

endmodule

// File: tb/tb_display_scan_7seg.sv
// Bench for display_scan_7seg at DIV=4.
// Reference model pushes expected outputs each edge; tasks pop and compare.
module tb_display_scan_7seg;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ligado = 1'b0;
  logic        carregar = 1'b0;
  logic [15:0] digitos = '0;
  logic [3:0]  pontos = '0;
  logic [1:0]  contador;
  logic [6:0]  segmentos;
  logic        ponto;
  logic        fim_varredura;

  int checks = 0;
  int errors = 0;

  logic [10:0] sb[$];
  logic [10:0] exp_v;

  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          m_div = 0;
  logic [1:0]  m_cnt = '0;
  logic [15:0] m_sd = '0;
  logic [15:0] m_ad = '0;
  logic [3:0]  m_sp = '0;
  logic [3:0]  m_ap = '0;

  always #5 clock = ~clock;

  display_scan_7seg #(.DIV(DIV)) dut (
    .clock(clock),
    .reset(reset),
    .ligado(ligado),
    .digitos(digitos),
    .pontos(pontos),
    .carregar(carregar),
    .contador(contador),
    .segmentos(segmentos),
    .ponto(ponto),
    .fim_varredura(fim_varredura)
  );

  function automatic logic [10:0] got();
    return {contador, segmentos, ponto, fim_varredura};
  endfunction

  function automatic logic [10:0] model_out();
    logic [6:0] s;
    logic p;
    logic f;
    f = ligado && (m_div == DIV - 1) && (m_cnt == 2'd3);
    s = ligado ? seg_tbl[m_ad[int'(m_cnt)*4 +: 4]] : 7'b1111111;
    p = ligado ? ~m_ap[m_cnt] : 1'b1;
    return {m_cnt, s, p, f};
  endfunction

  task automatic drive_edge();
    logic tk;
    logic fm;
    @(posedge clock);
    tk = ligado && (m_div == DIV - 1);
    fm = tk && (m_cnt == 2'd3);
    if (reset) begin
      m_div = 0; m_cnt = '0;
      m_sd = '0; m_sp = '0; m_ad = '0; m_ap = '0;
    end else begin
      if (fm) begin m_ad = m_sd; m_ap = m_sp; end
      if (carregar) begin m_sd = digitos; m_sp = pontos; end
      if (!ligado) begin m_div = 0; m_cnt = '0; end
      else if (tk) begin m_div = 0; m_cnt = m_cnt + 2'd1; end
      else m_div = m_div + 1;
    end
    sb.push_back(model_out());
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; ligado = 1'b0;
    drive_edge();
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v) begin
      errors++; $display("FAIL reset_off got %b exp %b", got(), exp_v);
    end
    checks++;
    if (got() !== {2'd0, 7'b1111111, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_off_const got %b exp %b", got(),
        {2'd0, 7'b1111111, 1'b1, 1'b0});
    end
    ligado = 1'b1;
    drive_edge();
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v) begin
      errors++; $display("FAIL reset_on got %b exp %b", got(), exp_v);
    end
    checks++;
    if (got() !== {2'd0, 7'b1000000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_on_const got %b exp %b", got(),
        {2'd0, 7'b1000000, 1'b1, 1'b0});
    end
  endtask

  task automatic test_scan();
    int fims = 0;
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      drive_edge();
      exp_v = sb.pop_front(); checks++;
      if (got() !== exp_v) begin
        errors++; $display("FAIL scan_model k=%0d got %b exp %b", k, got(), exp_v);
      end
      checks++;
      if (contador !== 2'((k / 4) % 4) || fim_varredura !== ((k % 16) == 15)) begin
        errors++;
        $display("FAIL scan_seq k=%0d got cnt=%0d fim=%b exp cnt=%0d fim=%b",
          k, contador, fim_varredura, (k / 4) % 4, (k % 16) == 15);
      end
      if (fim_varredura === 1'b1) fims++;
    end
    checks++;
    if (fims != 2) begin
      errors++; $display("FAIL scan_fim_count got %0d exp 2", fims);
    end
  endtask

  task automatic wait_fim(input string tag);
    int n = 0;
    while (fim_varredura !== 1'b1 && n < 64) begin
      drive_edge();
      exp_v = sb.pop_front(); checks++;
      if (got() !== exp_v) begin
        errors++; $display("FAIL %s_wait got %b exp %b", tag, got(), exp_v);
      end
      n++;
    end
    checks++;
    if (fim_varredura !== 1'b1) begin
      errors++; $display("FAIL %s_timeout got fim=%b exp 1", tag, fim_varredura);
    end
  endtask

  task automatic wait_cnt(input logic [1:0] c, input string tag);
    int n = 0;
    while (contador !== c && n < 64) begin
      drive_edge();
      exp_v = sb.pop_front(); checks++;
      if (got() !== exp_v) begin
        errors++; $display("FAIL %s_wait got %b exp %b", tag, got(), exp_v);
      end
      n++;
    end
    checks++;
    if (contador !== c) begin
      errors++; $display("FAIL %s_timeout got cnt=%0d exp %0d", tag, contador, c);
    end
  endtask

  task automatic test_load();
    logic [6:0] es [4] = '{7'b1111001, 7'b0110000, 7'b0001000, 7'b0000000};
    logic       ep [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    wait_cnt(2'd1, "load");
    carregar = 1'b1; digitos = 16'h8A31; pontos = 4'b0100;
    drive_edge();
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v || segmentos !== 7'b1000000) begin
      errors++; $display("FAIL load_hold got %b exp %b", got(), exp_v);
    end
    carregar = 1'b0;
    wait_fim("load");
    checks++;
    if (segmentos !== 7'b1000000) begin
      errors++; $display("FAIL load_old got %b exp 1000000", segmentos);
    end
    for (int i = 0; i < 16; i++) begin
      drive_edge();
      exp_v = sb.pop_front(); checks++;
      if (got() !== exp_v) begin
        errors++; $display("FAIL load_model got %b exp %b", got(), exp_v);
      end
      checks++;
      if (segmentos !== es[contador] || ponto !== ep[contador]) begin
        errors++;
        $display("FAIL load_digit cnt=%0d got %b/%b exp %b/%b", contador,
          segmentos, ponto, es[contador], ep[contador]);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_cnt(2'd1, "b2b");
    carregar = 1'b1; digitos = 16'h2222; pontos = 4'b0000;
    drive_edge();
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v) begin
      errors++; $display("FAIL b2b_load got %b exp %b", got(), exp_v);
    end
    carregar = 1'b0;
    wait_fim("b2b_a");
    carregar = 1'b1; digitos = 16'h5555;
    drive_edge();
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v) begin
      errors++; $display("FAIL b2b_wrap got %b exp %b", got(), exp_v);
    end
    carregar = 1'b0;
    checks++;
    if (contador !== 2'd0 || segmentos !== 7'b0100100) begin
      errors++; $display("FAIL b2b_prev got cnt=%0d seg=%b exp 0/0100100",
        contador, segmentos);
    end
    wait_fim("b2b_b");
    drive_edge();
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v) begin
      errors++; $display("FAIL b2b_wrap2 got %b exp %b", got(), exp_v);
    end
    checks++;
    if (segmentos !== 7'b0010010) begin
      errors++; $display("FAIL b2b_new got %b exp 0010010", segmentos);
    end
  endtask

  task automatic test_disable();
    int n = 0;
    wait_cnt(2'd2, "dis");
    ligado = 1'b0;
    drive_edge();
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v) begin
      errors++; $display("FAIL dis_model got %b exp %b", got(), exp_v);
    end
    checks++;
    if (got() !== {2'd0, 7'b1111111, 1'b1, 1'b0}) begin
      errors++; $display("FAIL dis_blank got %b exp %b", got(),
        {2'd0, 7'b1111111, 1'b1, 1'b0});
    end
    carregar = 1'b1; digitos = 16'h0007; pontos = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      drive_edge();
      carregar = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (got() !== exp_v || fim_varredura !== 1'b0) begin
        errors++; $display("FAIL dis_hold got %b exp %b", got(), exp_v);
      end
    end
    ligado = 1'b1;
    while (contador === 2'd0 && n < 20) begin
      drive_edge();
      exp_v = sb.pop_front(); checks++;
      if (got() !== exp_v) begin
        errors++; $display("FAIL dis_restart got %b exp %b", got(), exp_v);
      end
      n++;
    end
    checks++;
    if (n != DIV) begin
      errors++; $display("FAIL dis_first_tick got %0d exp %0d", n, DIV);
    end
    checks++;
    if (segmentos !== 7'b0010010) begin
      errors++; $display("FAIL dis_active_held got %b exp 0010010", segmentos);
    end
    wait_fim("dis");
    drive_edge();
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v || segmentos !== 7'b1111000) begin
      errors++; $display("FAIL dis_shadow_load got %b exp %b", got(), exp_v);
    end
  endtask

  task automatic test_reset_mid();
    wait_cnt(2'd3, "rst");
    reset = 1'b1; carregar = 1'b1; digitos = 16'hFFFF; pontos = 4'hF;
    drive_edge();
    reset = 1'b0; carregar = 1'b0;
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v) begin
      errors++; $display("FAIL rst_model got %b exp %b", got(), exp_v);
    end
    checks++;
    if (contador !== 2'd0 || segmentos !== 7'b1000000 || ponto !== 1'b1) begin
      errors++; $display("FAIL rst_mid got cnt=%0d seg=%b pt=%b exp 0/1000000/1",
        contador, segmentos, ponto);
    end
    wait_fim("rst");
    drive_edge();
    exp_v = sb.pop_front(); checks++;
    if (got() !== exp_v || segmentos !== 7'b1000000 || ponto !== 1'b1) begin
      errors++; $display("FAIL rst_shadow_clear got %b exp %b", got(), exp_v);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      carregar = 1'b1; digitos = {12'h000, 4'(v)}; pontos = 4'b0000;
      drive_edge();
      carregar = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (got() !== exp_v) begin
        errors++; $display("FAIL sweep_load v=%0d got %b exp %b", v, got(), exp_v);
      end
      wait_fim("sweep");
      drive_edge();
      exp_v = sb.pop_front(); checks++;
      if (got() !== exp_v) begin
        errors++; $display("FAIL sweep_model v=%0d got %b exp %b", v, got(), exp_v);
      end
      checks++;
      if (contador !== 2'd0 || segmentos !== seg_tbl[v]) begin
        errors++; $display("FAIL sweep_seg v=%0d got %b exp %b", v, segmentos, seg_tbl[v]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
